hdb3_decode: RTL and testbench

Streaming HDB3 line decoder, the receive-side counterpart of HDB3_code. It accepts one ternary symbol per valid cycle and removes the 000V/B00V substitutions to recover the original NRZ bit stream. It also flags HDB3 code-rule violations. It sits between the line-symbol slicer and the bit-level consumer.

---
 rtl/hdb3_pkg.sv | 25 ++
 rtl/hdb3_sym_classify.sv | 91 +++++++++
 rtl/hdb3_decode.sv | 106 ++++++++++
 tb/tb_hdb3_decode.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdb3_pkg.sv
// hdb3_pkg: constants shared by the HDB3 encoder and decoder.
//   SYM_*           2-bit ternary line-symbol encodings
//   pol_e           pulse polarity (POL_POS / POL_NEG)
//   HDB3_MAX_ZEROS  longest legal run of line zeros
//   sym_pol()       polarity of a pulse symbol
package hdb3_pkg;

    localparam logic [1:0] SYM_ZERO = 2'b00;
    localparam logic [1:0] SYM_POS  = 2'b01;
    localparam logic [1:0] SYM_NEG  = 2'b10;
    localparam logic [1:0] SYM_ILL  = 2'b11;

    typedef enum logic {
        POL_POS = 1'b0,
        POL_NEG = 1'b1
    } pol_e;

    localparam int HDB3_MAX_ZEROS = 3;

    // Only meaningful for SYM_POS / SYM_NEG.
    function automatic pol_e sym_pol(input logic [1:0] sym);
        return (sym == SYM_POS) ? POL_POS : POL_NEG;
    endfunction

endpackage

// File: rtl/hdb3_sym_classify.sv
// hdb3_sym_classify: judges each accepted line symbol against the running
// polarity / zero-run history and updates that history.
//   sys_clk, sys_rst_n  clock, synchronous active-low reset
//   sym_i               line symbol
//   accept_i            sym_i is consumed this cycle
//   is_one_o            symbol decodes to a 1 (alternating mark)
//   is_v_o              symbol is a V pulse (repeats last polarity)
//   code_err_o          symbol breaks an HDB3 code rule
// Outputs are combinational from the held history and sym_i so the top
// level can act on them in the same accept cycle.
module hdb3_sym_classify
    import hdb3_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] sym_i,
    input  logic       accept_i,
    output logic       is_one_o,
    output logic       is_v_o,
    output logic       code_err_o
);

    localparam logic [2:0] MAX_ZEROS = 3'(HDB3_MAX_ZEROS);

    pol_e       last_pol_q,  last_pol_d;
    pol_e       last_vpol_q, last_vpol_d;
    logic       v_seen_q,    v_seen_d;
    logic [2:0] zero_run_q,  zero_run_d;
    pol_e       pol;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        is_one_o    = 1'b0;
        is_v_o      = 1'b0;
        code_err_o  = 1'b0;
        last_pol_d  = last_pol_q;
        last_vpol_d = last_vpol_q;
        v_seen_d    = v_seen_q;
        zero_run_d  = zero_run_q;
        pol         = sym_pol(sym_i);

        if (accept_i) begin
            if (sym_i == SYM_POS || sym_i == SYM_NEG) begin
                zero_run_d = 3'd0;
                if (pol != last_pol_q) begin
                    is_one_o   = 1'b1;
                    last_pol_d = pol;
                end else begin
                    is_v_o      = 1'b1;
                    last_vpol_d = pol;
                    v_seen_d    = 1'b1;
                    // A V must follow at least two zeros (000V or B00V) and
                    // successive Vs must alternate.
                    if (zero_run_q < 3'd2)
                        code_err_o = 1'b1;
                    if (v_seen_q && pol == last_vpol_q)
                        code_err_o = 1'b1;
                end
            end else begin
                // Illegal symbols update history exactly like a zero.
                if (sym_i == SYM_ILL)
                    code_err_o = 1'b1;
                // Fires on the zero that makes the run exceed the limit.
                if (zero_run_q >= MAX_ZEROS)
                    code_err_o = 1'b1;
                if (zero_run_q != 3'd7)
                    zero_run_d = zero_run_q + 3'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked
        // block rather than placed in the sensitivity list.
        if (!sys_rst_n) begin
            last_pol_q  <= POL_NEG;  // first + pulse is then a normal mark
            last_vpol_q <= POL_NEG;
            v_seen_q    <= 1'b0;
            zero_run_q  <= 3'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            last_pol_q  <= last_pol_d;
            last_vpol_q <= last_vpol_d;
            v_seen_q    <= v_seen_d;
            zero_run_q  <= zero_run_d;
        end
    end

endmodule

// File: rtl/hdb3_decode.sv
// hdb3_decode: streaming HDB3 line decoder with code-rule checking.
//   sys_clk, sys_rst_n  clock, synchronous active-low reset
//   sym_i, sym_valid_i  line symbol and its accept strobe
//   flush_i             drain one pipeline entry when no symbol is accepted
//   data_o              decoded NRZ bit (held between strobes)
//   data_valid_o        data_o strobe
//   viol_o              accepted symbol was a V pulse
//   err_o               accepted symbol broke a code rule
//   err_cnt_o           saturating count of err_o strobes
// A symbol's bit leaves DLY accepted symbols later, so when a V arrives
// the three preceding symbols are still buffered and can be cleared.
module hdb3_decode
    import hdb3_pkg::*;
#(
    parameter int ERR_CNT_W = 16,
    parameter int DLY       = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [1:0]           sym_i,
    input  logic                 sym_valid_i,
    input  logic                 flush_i,
    output logic                 data_o,
    output logic                 data_valid_o,
    output logic                 viol_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    logic                 is_one, is_v, code_err;
    logic [DLY-1:0]       d_q, d_d;  // bit 0 is the newest entry
    logic [DLY-1:0]       v_q, v_d;
    logic                 data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 viol_q, viol_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    hdb3_sym_classify u_classify (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .sym_i      (sym_i),
        .accept_i   (sym_valid_i),
        .is_one_o   (is_one),
        .is_v_o     (is_v),
        .code_err_o (code_err)
    );

    always_comb begin
        d_d    = d_q;
        v_d    = v_q;
        data_d = data_q;
        dv_d   = 1'b0;
        viol_d = 1'b0;
        err_d  = 1'b0;
        cnt_d  = cnt_q;

        if (sym_valid_i) begin
            d_d = {d_q[DLY-2:0], is_one};
            v_d = {v_q[DLY-2:0], 1'b1};
            // Undo the substitution: the B (if any) and the two zeros ahead
            // of V become plain zeros; their valid flags are kept.
            if (is_v)
                d_d[DLY-1:1] = '0;
            data_d = d_q[DLY-1];
            dv_d   = v_q[DLY-1];
            viol_d = is_v;
            err_d  = code_err;
        end else if (flush_i) begin
            d_d    = {d_q[DLY-2:0], 1'b0};
            v_d    = {v_q[DLY-2:0], 1'b0};
            data_d = d_q[DLY-1];
            dv_d   = v_q[DLY-1];
        end

        if (err_d && cnt_q != '1)
            cnt_d = cnt_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            d_q    <= '0;
            v_q    <= '0;
            data_q <= 1'b0;
            dv_q   <= 1'b0;
            viol_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            d_q    <= d_d;
            v_q    <= v_d;
            data_q <= data_d;
            dv_q   <= dv_d;
            viol_q <= viol_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = dv_q;
    assign viol_o       = viol_q;
    assign err_o        = err_q;
    assign err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_hdb3_decode.sv
// tb_hdb3_decode: directed bench for hdb3_decode.
module tb_hdb3_decode;

    localparam int ERR_CNT_W = 16;
    localparam logic [1:0] Z = 2'b00;
    localparam logic [1:0] P = 2'b01;
    localparam logic [1:0] N = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n;
    logic [1:0]           sym_i;
    logic                 sym_valid_i;
    logic                 flush_i;
    logic                 data_o;
    logic                 data_valid_o;
    logic                 viol_o;
    logic                 err_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;

    int tests_run    = 0;
    int tests_failed = 0;
    bit got_q[$];

    // Team vector 1000010000110000000011 and its HDB3 line encoding.
    logic [1:0]  team_syms [22] = '{P,Z,Z,Z,P,N,Z,Z,Z,N,P,N,P,Z,Z,P,N,Z,Z,N,P,N};
    logic [21:0] team_bits = 22'b1000010000110000000011;

    hdb3_decode #(.ERR_CNT_W(ERR_CNT_W), .DLY(4)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .sym_i        (sym_i),
        .sym_valid_i  (sym_valid_i),
        .flush_i      (flush_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .viol_o       (viol_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic cyc(input logic [1:0] s, input logic v, input logic f);
        @(negedge sys_clk);
        sym_i       = s;
        sym_valid_i = v;
        flush_i     = f;
        @(posedge sys_clk);
        #1;
        if (data_valid_o)
            got_q.push_back(data_o);
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        cyc(Z, 1'b0, 1'b0);
        cyc(Z, 1'b0, 1'b0);
        sys_rst_n = 1'b1;
        got_q.delete();
    endtask

    task automatic flush4();
        for (int i = 0; i < 4; i++)
            cyc(Z, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({data_o, data_valid_o, viol_o, err_o} !== 4'b0000 || err_cnt_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got d=%b dv=%b v=%b e=%b cnt=%0d, want all 0",
                     data_o, data_valid_o, viol_o, err_o, err_cnt_o);
        end
    endtask

    task automatic test_team_vector();
        logic [21:0] got_v;
        logic        exp_viol;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            cyc(team_syms[i], 1'b1, 1'b0);
            exp_viol = (i == 4 || i == 9 || i == 15 || i == 19);
            tests_run++;
            if (viol_o !== exp_viol || err_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL team_sym%0d: got viol=%b err=%b, want viol=%b err=0",
                         i + 1, viol_o, err_o, exp_viol);
            end
        end
        flush4();
        got_v = '0;
        for (int i = 0; i < got_q.size() && i < 22; i++)
            got_v[21-i] = got_q[i];
        tests_run++;
        if (got_q.size() !== 22 || got_v !== team_bits) begin
            tests_failed++;
            $display("FAIL team_bits: got %0d strobes %b, want 22 strobes %b",
                     got_q.size(), got_v, team_bits);
        end
        tests_run++;
        if (err_cnt_o !== '0) begin
            tests_failed++;
            $display("FAIL team_errcnt: got %0d, want 0", err_cnt_o);
        end
    endtask

    task automatic test_idle_gaps();
        logic [21:0] got_v;
        int          idle_strobes = 0;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            if (i % 3 == 1) begin
                for (int g = 0; g < 2; g++) begin
                    cyc(P, 1'b0, 1'b0);
                    if (data_valid_o || viol_o || err_o)
                        idle_strobes++;
                end
            end
            cyc(team_syms[i], 1'b1, 1'b0);
        end
        flush4();
        got_v = '0;
        for (int i = 0; i < got_q.size() && i < 22; i++)
            got_v[21-i] = got_q[i];
        tests_run++;
        if (got_q.size() !== 22 || got_v !== team_bits) begin
            tests_failed++;
            $display("FAIL gaps_bits: got %0d strobes %b, want 22 strobes %b",
                     got_q.size(), got_v, team_bits);
        end
        tests_run++;
        if (idle_strobes !== 0) begin
            tests_failed++;
            $display("FAIL gaps_idle_strobe: got %0d strobes on idle cycles, want 0", idle_strobes);
        end
    endtask

    task automatic test_zero_run();
        logic [1:0] syms [5] = '{P, Z, Z, Z, Z};
        logic [4:0] got_v;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(syms[i], 1'b1, 1'b0);
            tests_run++;
            if (err_o !== (i == 4)) begin
                tests_failed++;
                $display("FAIL zrun_sym%0d: got err=%b, want %b", i + 1, err_o, (i == 4));
            end
        end
        flush4();
        got_v = '0;
        for (int i = 0; i < got_q.size() && i < 5; i++)
            got_v[4-i] = got_q[i];
        tests_run++;
        if (got_q.size() !== 5 || got_v !== 5'b10000 || err_cnt_o !== 16'd1) begin
            tests_failed++;
            $display("FAIL zrun_bits: got %0d strobes %b cnt=%0d, want 5 strobes 10000 cnt=1",
                     got_q.size(), got_v, err_cnt_o);
        end
    endtask

    task automatic test_v_errors();
        logic [1:0] syms [10] = '{P, Z, Z, Z, P, N, P, Z, Z, P};
        do_reset();
        cyc(P, 1'b1, 1'b0);
        cyc(P, 1'b1, 1'b0);
        tests_run++;
        if (viol_o !== 1'b1 || err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL v_close: got viol=%b err=%b, want viol=1 err=1", viol_o, err_o);
        end
        // Second V (symbol 10, after B00) repeats the first V's + polarity.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(syms[i], 1'b1, 1'b0);
            if (i == 4) begin
                tests_run++;
                if (viol_o !== 1'b1 || err_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL v_first: got viol=%b err=%b, want viol=1 err=0", viol_o, err_o);
                end
            end
        end
        tests_run++;
        if (viol_o !== 1'b1 || err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL v_same_pol: got viol=%b err=%b, want viol=1 err=1", viol_o, err_o);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] got_v;
        do_reset();
        cyc(P, 1'b1, 1'b0);
        cyc(X, 1'b1, 1'b0);
        tests_run++;
        if (err_o !== 1'b1 || viol_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ill_flag: got err=%b viol=%b, want err=1 viol=0", err_o, viol_o);
        end
        // Judged against last_pol=+ from before the illegal symbol.
        cyc(N, 1'b1, 1'b0);
        tests_run++;
        if (err_o !== 1'b0 || viol_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ill_next_pulse: got err=%b viol=%b, want err=0 viol=0", err_o, viol_o);
        end
        flush4();
        got_v = '0;
        for (int i = 0; i < got_q.size() && i < 3; i++)
            got_v[2-i] = got_q[i];
        tests_run++;
        if (got_q.size() !== 3 || got_v !== 3'b101 || err_cnt_o !== 16'd1) begin
            tests_failed++;
            $display("FAIL ill_bits: got %0d strobes %b cnt=%0d, want 3 strobes 101 cnt=1",
                     got_q.size(), got_v, err_cnt_o);
        end
    endtask

    task automatic test_err_saturate();
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            cyc(X, 1'b1, 1'b0);
            if (got_q.size() > 8)
                got_q.delete();
        end
        tests_run++;
        if (err_cnt_o !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_reach: got %0d, want 65535", err_cnt_o);
        end
        for (int i = 0; i < 4; i++)
            cyc(X, 1'b1, 1'b0);
        tests_run++;
        if (err_cnt_o !== 16'hFFFF || err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_hold: got cnt=%0d err=%b, want cnt=65535 err=1", err_cnt_o, err_o);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        cyc(P, 1'b1, 1'b0);
        cyc(N, 1'b1, 1'b0);
        cyc(P, 1'b1, 1'b0);
        sys_rst_n = 1'b0;
        cyc(Z, 1'b0, 1'b0);
        sys_rst_n = 1'b1;
        tests_run++;
        if ({data_o, data_valid_o, viol_o, err_o} !== 4'b0000 || err_cnt_o !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got d=%b dv=%b v=%b e=%b cnt=%0d, want all 0",
                     data_o, data_valid_o, viol_o, err_o, err_cnt_o);
        end
        got_q.delete();
        flush4();
        tests_run++;
        if (got_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL mid_reset_discard: got %0d strobes, want 0", got_q.size());
        end
        cyc(P, 1'b1, 1'b0);
        tests_run++;
        if (viol_o !== 1'b0 || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_lead_pos: got viol=%b err=%b, want 0 0", viol_o, err_o);
        end
        flush4();
        tests_run++;
        if (got_q.size() !== 1 || (got_q.size() == 1 && got_q[0] !== 1'b1)) begin
            tests_failed++;
            $display("FAIL mid_reset_bit: got %0d strobes (first=%b), want 1 strobe of 1",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 1'b0);
        end
    endtask

    initial begin
        sys_rst_n   = 1'b0;
        sym_i       = Z;
        sym_valid_i = 1'b0;
        flush_i     = 1'b0;
        test_reset();
        test_team_vector();
        test_idle_gaps();
        test_zero_run();
        test_v_errors();
        test_illegal();
        test_reset_midstream();
        test_err_saturate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
